// File: rtl/vga_pixel_reader.sv
// vga_pixel_reader: ping-pong line-buffer consumer feeding the VGA path.
// Optional: define VGA_READER_UNDERRUN_CNT_EN for the underrun_cnt output.
module vga_pixel_reader #(
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 16,
  parameter int FILL_CYCLES  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PIX_W*PIX_PER_WORD-1:0] R_inRegA,
  input  logic [PIX_W*PIX_PER_WORD-1:0] G_inRegA,
  input  logic [PIX_W*PIX_PER_WORD-1:0] B_inRegA,
  input  logic [PIX_W*PIX_PER_WORD-1:0] R_inRegB,
  input  logic [PIX_W*PIX_PER_WORD-1:0] G_inRegB,
  input  logic [PIX_W*PIX_PER_WORD-1:0] B_inRegB,
  input  logic                          pixel_req,
  input  logic                          frame_start,
  output logic                          readVgaSelector,
  output logic [PIX_W-1:0]              R_out,
  output logic [PIX_W-1:0]              G_out,
  output logic [PIX_W-1:0]              B_out,
  output logic                          pixel_valid,
`ifdef VGA_READER_UNDERRUN_CNT_EN
  output logic [15:0]                   underrun_cnt,
`endif
  output logic                          underrun
);

  localparam int IDX_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int TMR_W = $clog2(FILL_CYCLES + 1);

  typedef enum logic [1:0] {
    WAIT_FILL = 2'd0,
    STREAM    = 2'd1,
    STALL     = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_sel;
  logic               w_sel_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [TMR_W-1:0]   r_fill_timer;
  logic               w_filled;
  logic               w_last;
  logic               w_serve;
  logic [PIX_W-1:0]   w_pix_r;
  logic [PIX_W-1:0]   w_pix_g;
  logic [PIX_W-1:0]   w_pix_b;
  int unsigned        w_base;

  assign w_filled = (r_fill_timer == TMR_W'(FILL_CYCLES));
  assign w_last   = (r_idx == IDX_W'(PIX_PER_WORD - 1));
  assign w_serve  = pixel_req && (r_state == STREAM);

  assign readVgaSelector = r_sel;

  // Pick the current pixel out of the bank the reader owns.
  always_comb begin
    w_base  = 32'(r_idx) * 32'(PIX_W);
    w_pix_r = r_sel ? R_inRegB[w_base +: PIX_W] : R_inRegA[w_base +: PIX_W];
    w_pix_g = r_sel ? G_inRegB[w_base +: PIX_W] : G_inRegA[w_base +: PIX_W];
    w_pix_b = r_sel ? B_inRegB[w_base +: PIX_W] : B_inRegA[w_base +: PIX_W];
  end

  // Next selector/state: bank swaps only once the writer has had its fill window.
  always_comb begin
    w_sel_nxt   = r_sel;
    w_state_nxt = r_state;
    if (frame_start) begin
      w_sel_nxt   = 1'b1;
      w_state_nxt = WAIT_FILL;
    end else begin
      unique case (r_state)
        WAIT_FILL: begin
          if (w_filled) begin
            w_sel_nxt   = 1'b0;
            w_state_nxt = STREAM;
          end
        end
        STREAM: begin
          if (pixel_req && w_last) begin
            if (w_filled) w_sel_nxt = ~r_sel;
            else w_state_nxt = STALL;
          end
        end
        STALL: begin
          if (w_filled) begin
            w_sel_nxt   = ~r_sel;
            w_state_nxt = STREAM;
          end
        end
        default: w_state_nxt = WAIT_FILL;
      endcase
    end
  end

  // Fill timer restarts whenever the selector flips, else saturating count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fill_timer <= '0;
    end else if (w_sel_nxt != r_sel) begin
      r_fill_timer <= '0;
    end else if (!w_filled) begin
      r_fill_timer <= r_fill_timer + TMR_W'(1);
    end
  end

  // Reader FSM: state, selector and pixel index within the owned bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_FILL;
      r_sel   <= 1'b1;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      if (frame_start) begin
        r_idx <= '0;
      end else if (r_state == WAIT_FILL && w_filled) begin
        r_idx <= '0;
      end else if (w_serve) begin
        r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  // Registered pixel outputs: real pixel when streaming, zero on underrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      R_out       <= '0;
      G_out       <= '0;
      B_out       <= '0;
      pixel_valid <= 1'b0;
      underrun    <= 1'b0;
    end else if (frame_start) begin
      R_out       <= '0;
      G_out       <= '0;
      B_out       <= '0;
      pixel_valid <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      pixel_valid <= pixel_req;
      underrun    <= pixel_req && !w_serve;
      if (w_serve) begin
        R_out <= w_pix_r;
        G_out <= w_pix_g;
        B_out <= w_pix_b;
      end else if (pixel_req) begin
        R_out <= '0;
        G_out <= '0;
        B_out <= '0;
      end
    end
  end

`ifdef VGA_READER_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  assign underrun_cnt = r_underrun_cnt;

  // Saturating count of underrun pulses since reset or frame restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_underrun_cnt <= '0;
    end else if (frame_start) begin
      r_underrun_cnt <= '0;
    end else if (pixel_req && !w_serve && r_underrun_cnt != 16'hFFFF) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end
`endif

endmodule
